// File: rtl/dmem_preloader.sv
// dmem_preloader: streams host bytes into little-endian 32-bit words and
// writes them into the CPU data memory while holding the CPU in reset.
// The CPU is released (cpu_reset=0) once the requested word count is loaded.
module dmem_preloader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_widx;
  logic [1:0]  r_bidx;
  logic [31:0] r_word;
  logic        w_last_word;

  assign w_last_word = (r_widx == (r_count - 16'd1));

  // Ext_DataAdr doubles as the running address register: it is loaded with
  // the aligned base on start and stepped by 4 per word, which equals
  // base + 4*index modulo 2^32.
  // Control FSM, byte assembly and registered memory-write interface.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_widx        <= '0;
      r_bidx        <= '0;
      r_word        <= '0;
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= '0;
      Ext_DataAdr   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          Ext_MemWrite <= 1'b0;
          if (start) begin
            r_count     <= word_count;
            r_widx      <= '0;
            r_bidx      <= '0;
            Ext_DataAdr <= base_addr & 32'hFFFF_FFFC;
            r_state     <= (word_count == 16'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (byte_valid) begin
            r_word[{r_bidx, 3'b000} +: 8] <= byte_data;
            if (r_bidx == 2'd3) begin
              Ext_WriteData <= {byte_data, r_word[23:0]};
              Ext_MemWrite  <= 1'b1;
              r_bidx        <= '0;
              r_state       <= S_WRITE;
            end else begin
              r_bidx <= r_bidx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          Ext_MemWrite <= 1'b0;
          if (w_last_word) begin
            r_state <= S_DONE;
          end else begin
            r_widx      <= r_widx + 16'd1;
            Ext_DataAdr <= Ext_DataAdr + 32'd4;
            r_state     <= S_COLLECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decoded purely from the current state.
  always_comb begin
    byte_ready = (r_state == S_COLLECT);
    busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
    done       = (r_state == S_DONE);
    cpu_reset  = (r_state != S_DONE);
  end

endmodule

// File: tb/tb_dmem_preloader.sv
// Directed testbench for dmem_preloader with a write scoreboard.
module tb_dmem_preloader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        busy;
  logic        done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_writes = 0;
  logic [63:0] sb_q[$];

  dmem_preloader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .cpu_reset    (cpu_reset),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    sb_q.push_back({addr, data});
  endtask

  // Present one byte and hold it until the DUT accepts it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    logic sent;
    sent = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 10 && !sent; i++) begin
      if (byte_ready === 1'b1) sent = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    if (!sent) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] wc);
    start = 1'b1;
    base_addr = b;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    chk({tag, "_memwrite"},  {31'd0, Ext_MemWrite}, 32'd0);
    chk({tag, "_wdata"},     Ext_WriteData, 32'd0);
    chk({tag, "_addr"},      Ext_DataAdr, 32'd0);
    chk({tag, "_ready"},     {31'd0, byte_ready}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
    chk({tag, "_done"},      {31'd0, done}, 32'd0);
  endtask

  // Scoreboard: every write strobe must match the next expected write and
  // may only occur while the CPU is held in reset.
  always @(negedge clk) begin
    if (Ext_MemWrite === 1'b1) begin
      n_writes++;
      chk("write_under_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      if (sb_q.size() == 0) begin
        chk("unexpected_write_addr", Ext_DataAdr, 32'hDEAD_BEEF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("write_addr", Ext_DataAdr, e[63:32]);
        chk("write_data", Ext_WriteData, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    byte_valid = 1'b0; byte_data = '0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Zero word count: straight to DONE, no writes
    do_start(32'h0000_1000, 16'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    tick();

    // Basic two-word load
    reset = 1'b1; tick(); reset = 1'b0; tick();
    push_write(32'h0000_0100, 32'h4433_2211);
    push_write(32'h0000_0104, 32'hDDCC_BBAA);
    do_start(32'h0000_0100, 16'd2);
    chk("basic_addr0", Ext_DataAdr, 32'h0000_0100);
    chk("basic_ready", {31'd0, byte_ready}, 32'd1);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("basic_lat_w0", {31'd0, Ext_MemWrite}, 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    chk("basic_lat_w1", {31'd0, Ext_MemWrite}, 32'd1);
    chk("basic_write_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_cpu_rel", {31'd0, cpu_reset}, 32'd0);
    chk("basic_memwrite_off", {31'd0, Ext_MemWrite}, 32'd0);

    // Restart from DONE; start during COLLECT is ignored
    push_write(32'h0000_0200, 32'h8765_4321);
    do_start(32'h0000_0200, 16'd1);
    chk("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("restart_addr", Ext_DataAdr, 32'h0000_0200);
    send_byte(8'h21);
    do_start(32'h0000_0999, 16'd7);
    chk("restart_ign_addr", Ext_DataAdr, 32'h0000_0200);
    send_byte(8'h43); send_byte(8'h65); send_byte(8'h87);
    tick();
    chk("restart_done", {31'd0, done}, 32'd1);
    chk("restart_hold_wdata", Ext_WriteData, 32'h8765_4321);

    // Host stalls: valid pattern 1,0,0,1,0,1,1
    push_write(32'h0000_0300, 32'h0403_0201);
    do_start(32'h0000_0300, 16'd1);
    byte_valid = 1'b1; byte_data = 8'h01; tick();
    byte_valid = 1'b0; byte_data = 8'hEE; tick();
    chk("stall_ready", {31'd0, byte_ready}, 32'd1);
    tick();
    chk("stall_addr", Ext_DataAdr, 32'h0000_0300);
    byte_valid = 1'b1; byte_data = 8'h02; tick();
    byte_valid = 1'b0; byte_data = 8'hEE; tick();
    byte_valid = 1'b1; byte_data = 8'h03; tick();
    byte_valid = 1'b1; byte_data = 8'h04; tick();
    byte_valid = 1'b0;
    chk("stall_write", {31'd0, Ext_MemWrite}, 32'd1);
    chk("stall_write_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    chk("stall_done", {31'd0, done}, 32'd1);

    // Unaligned base with address wrap
    push_write(32'hFFFF_FFFC, 32'h7777_6655);
    push_write(32'h0000_0000, 32'h0B0A_0908);
    do_start(32'hFFFF_FFFE, 16'd2);
    chk("wrap_addr0", Ext_DataAdr, 32'hFFFF_FFFC);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h77);
    send_byte(8'h08); send_byte(8'h09); send_byte(8'h0A); send_byte(8'h0B);
    tick();
    chk("wrap_done", {31'd0, done}, 32'd1);

    // Mid-load reset after two bytes of word 1
    push_write(32'h0000_0400, 32'h1312_1110);
    do_start(32'h0000_0400, 16'd2);
    send_byte(8'h10); send_byte(8'h11); send_byte(8'h12); send_byte(8'h13);
    send_byte(8'hA0); send_byte(8'hA1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset_vals("midrst");
    tick();
    push_write(32'h0000_0500, 32'hC3C2_C1C0);
    do_start(32'h0000_0500, 16'd1);
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    tick();
    chk("reload_done", {31'd0, done}, 32'd1);
    tick();

    chk("sb_empty", sb_q.size(), 32'd0);
    chk("write_count", n_writes, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_preloader.md
DMEM_PRELOADER -- requirements
Module: dmem_preloader

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, one-cycle load request, sampled in IDLE and DONE only.
REQ-004 SHALL have port base_addr, input, 32, first write byte address, latched on accepted start.
REQ-005 SHALL have port word_count, input, 16, number of 32-bit words to load, latched on accepted start.
REQ-006 SHALL have port byte_valid, input, 1, host byte present.
REQ-007 SHALL have port byte_data, input, 8, host byte.
REQ-008 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port cpu_reset, output, 1, drives the CPU wrapper reset.
REQ-010 SHALL have port Ext_MemWrite, output, 1, data-memory write strobe to the CPU wrapper.
REQ-011 SHALL have port Ext_WriteData, output, 32, word to write.
REQ-012 SHALL have port Ext_DataAdr, output, 32, write address.
REQ-013 SHALL have port busy, output, 1, load in progress.
REQ-014 SHALL have port done, output, 1, load complete and CPU released.

Function
REQ-015 SHALL implement states IDLE, COLLECT, WRITE, DONE; all outputs SHALL be registered or decoded from state only.
REQ-016 IDLE: cpu_reset=1, byte_ready=0, busy=0, done=0; start=1 latches base_addr with bits [1:0] forced to 0 and latches word_count.
REQ-017 On an accepted start with word_count=0, the next state SHALL be DONE; otherwise it SHALL be COLLECT with word index 0 and byte index 0.
REQ-018 COLLECT: byte_ready=1, busy=1; a byte is accepted only when byte_valid and byte_ready are both 1.
REQ-019 Assembly SHALL be little-endian: accepted byte k (k=0..3) is written to word bits [8k+7:8k].
REQ-020 On acceptance of byte 3, the next state SHALL be WRITE and the byte index SHALL return to 0.
REQ-021 WRITE lasts exactly one cycle: Ext_MemWrite=1, byte_ready=0, Ext_WriteData=the assembled word, Ext_DataAdr=latched base + 4*word index, with modulo-2^32 wrap.
REQ-022 After WRITE, if word index = word_count-1 the next state SHALL be DONE; otherwise the word index increments and the next state is COLLECT.
REQ-023 Write latency: Ext_MemWrite SHALL assert on the cycle immediately after the cycle that accepts byte 3.
REQ-024 Ext_DataAdr SHALL show the current word's address throughout COLLECT and WRITE; Ext_WriteData SHALL hold its last written value outside WRITE.
REQ-025 Ext_MemWrite=1 SHALL only occur while cpu_reset=1, because the wrapper honours external writes only under reset.
REQ-026 DONE: cpu_reset=0, done=1, busy=0, byte_ready=0.
REQ-027 start=1 in DONE SHALL reassert cpu_reset on the next cycle and restart the load exactly as from IDLE (same latching, same REQ-017 check).
REQ-028 start SHALL be ignored in COLLECT and WRITE.
REQ-029 byte_valid SHALL be ignored outside COLLECT; no byte is lost or double-counted across the COLLECT/WRITE boundary.
REQ-030 A host stall (byte_valid=0) in COLLECT SHALL hold all state indefinitely.

Reset
REQ-031 reset=1 at a clock edge SHALL force: state IDLE, cpu_reset=1, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0, byte_ready=0, busy=0, done=0, word index and byte index 0, assembled word 0.
REQ-032 reset SHALL take priority over all other inputs, including during WRITE; a partial word SHALL be discarded and no write issued.

Verification
REQ-033 Basic load: base_addr=0x100, word_count=2, bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD -> writes 0x44332211@0x100, then 0xDDCCBBAA@0x104; done=1 and cpu_reset=0 on the cycle after the second write.
REQ-034 Zero count: start with word_count=0 -> DONE one cycle after start; no Ext_MemWrite pulse at any point.
REQ-035 Stalls: byte_valid toggles 1,0,0,1,0,1,1 carrying 0x01..0x04 -> single write of 0x04030201; byte_ready=0 during the WRITE cycle.
REQ-036 Alignment/wrap: base_addr=0xFFFFFFFE, word_count=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-037 Mid-load reset: reset asserted after 2 bytes of word 1 -> all outputs at reset values next cycle; no write issued; a new start reloads correctly.
REQ-038 Restart: start pulsed in DONE, base_addr=0x200, word_count=1 -> cpu_reset=1 the next cycle, one write at 0x200, DONE again; start pulses during COLLECT have no effect.
